// File: rtl/sdram_arbiter_if.sv
// Client-port and controller-side signal bundle for the SDRAM arbiter.
// The master modport is the arbiter's view; slave is the view of clients plus controller.
interface sdram_arbiter_if;
   logic        ready;

   logic        a_req;
   logic        a_we;
   logic [23:0] a_addr;
   logic [15:0] a_din;
   logic [1:0]  a_bs;
   logic [15:0] a_dout;
   logic        a_ack;

   logic        b_req;
   logic        b_we;
   logic [23:0] b_addr;
   logic [15:0] b_din;
   logic [1:0]  b_bs;
   logic [15:0] b_dout;
   logic        b_ack;

   logic        mem_ce;
   logic        mem_we;
   logic        mem_refresh;
   logic [23:0] mem_addr;
   logic [15:0] mem_din;
   logic [1:0]  mem_bs;
   logic [15:0] mem_dout;

   modport master (
      output ready,
      input  a_req, a_we, a_addr, a_din, a_bs,
      output a_dout, a_ack,
      input  b_req, b_we, b_addr, b_din, b_bs,
      output b_dout, b_ack,
      output mem_ce, mem_we, mem_refresh, mem_addr, mem_din, mem_bs,
      input  mem_dout
   );

   modport slave (
      input  ready,
      output a_req, a_we, a_addr, a_din, a_bs,
      input  a_dout, a_ack,
      output b_req, b_we, b_addr, b_din, b_bs,
      input  b_dout, b_ack,
      input  mem_ce, mem_we, mem_refresh, mem_addr, mem_din, mem_bs,
      output mem_dout
   );
endinterface

// File: rtl/sdram_arbiter.sv
// Sequencer in front of the SDRAM controller: runs the power-up refresh burst, then
// arbitrates refresh > port A > port B and drives held ce/refresh strobes with a one-clock gap.
module sdram_arbiter #(
   parameter int CYCLE_LEN        = 8,
   parameter int DATA_SAMPLE      = 7,
   parameter int REFRESH_INTERVAL = 999,
   parameter int INIT_CYCLES      = 1610
) (
   input logic              clk,
   input logic              reset,
   sdram_arbiter_if.master  bus
);

   localparam int CNT_W  = $clog2(CYCLE_LEN);
   localparam int INIT_W = $clog2(INIT_CYCLES);
   localparam int TMR_W  = $clog2(REFRESH_INTERVAL);

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_RUN,
      S_GAP
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [CNT_W-1:0]    r_cnt;
   logic [INIT_W-1:0]   r_initCnt;
   logic [TMR_W-1:0]    r_refTimer;
   logic                r_pending;
   logic                r_ready;
   logic                r_isRef;
   logic                r_portB;
   logic                r_we;
   logic [23:0]         r_addr;
   logic [15:0]         r_din;
   logic [1:0]          r_bs;
   logic [15:0]         r_aDout;
   logic [15:0]         r_bDout;

   logic                w_grantRef;
   logic                w_grantA;
   logic                w_grantB;
   logic                w_initDone;
   logic                w_wrap;
   logic                w_runLast;
   logic                w_sample;

   assign w_runLast = (r_cnt == CNT_W'(CYCLE_LEN - 1));
   assign w_wrap    = r_ready && (r_refTimer == TMR_W'(REFRESH_INTERVAL - 1));
   assign w_sample  = (r_state == S_RUN) && !r_isRef && !r_we && (r_cnt == CNT_W'(DATA_SAMPLE));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_INIT;
      else       r_state <= w_nextState;
   end

   // During init every GAP chains straight into another refresh; after ready we always pass through IDLE.
   always_comb begin
      w_nextState = r_state;
      w_grantRef  = 1'b0;
      w_grantA    = 1'b0;
      w_grantB    = 1'b0;
      w_initDone  = 1'b0;
      case (r_state)
         S_INIT: begin
            w_grantRef  = 1'b1;
            w_nextState = S_RUN;
         end
         S_IDLE: begin
            if (r_pending)       w_grantRef = 1'b1;
            else if (bus.a_req)  w_grantA   = 1'b1;
            else if (bus.b_req)  w_grantB   = 1'b1;
            if (r_pending || bus.a_req || bus.b_req) w_nextState = S_RUN;
         end
         S_RUN: begin
            if (w_runLast) w_nextState = S_GAP;
         end
         S_GAP: begin
            if (r_ready) begin
               w_nextState = S_IDLE;
            end else if (r_initCnt == INIT_W'(INIT_CYCLES - 1)) begin
               w_initDone  = 1'b1;
               w_nextState = S_IDLE;
            end else begin
               w_grantRef  = 1'b1;
               w_nextState = S_RUN;
            end
         end
         default: w_nextState = S_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_grantRef || w_grantA || w_grantB) begin
         r_cnt <= '0;
      end else if (r_state == S_RUN) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Command fields are frozen at the grant edge so the controller sees them steady for the whole cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_isRef <= 1'b0;
         r_portB <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_din   <= '0;
         r_bs    <= '0;
      end else if (w_grantRef) begin
         r_isRef <= 1'b1;
         r_we    <= 1'b0;
      end else if (w_grantA) begin
         r_isRef <= 1'b0;
         r_portB <= 1'b0;
         r_we    <= bus.a_we;
         r_addr  <= bus.a_addr;
         r_din   <= bus.a_din;
         r_bs    <= bus.a_bs;
      end else if (w_grantB) begin
         r_isRef <= 1'b0;
         r_portB <= 1'b1;
         r_we    <= bus.b_we;
         r_addr  <= bus.b_addr;
         r_din   <= bus.b_din;
         r_bs    <= bus.b_bs;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_initCnt <= '0;
         r_ready   <= 1'b0;
      end else begin
         if ((r_state == S_GAP) && !r_ready) r_initCnt <= r_initCnt + 1'b1;
         if (w_initDone)                     r_ready   <= 1'b1;
      end
   end

   // A wrap landing on the same edge as a refresh grant wins, so that refresh is not lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_refTimer <= '0;
         r_pending  <= 1'b0;
      end else begin
         if (r_ready) r_refTimer <= w_wrap ? '0 : r_refTimer + 1'b1;
         if (w_wrap)                       r_pending <= 1'b1;
         else if (w_grantRef && r_ready)   r_pending <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_aDout <= '0;
         r_bDout <= '0;
      end else if (w_sample) begin
         if (r_portB) r_bDout <= bus.mem_dout;
         else         r_aDout <= bus.mem_dout;
      end
   end

   assign bus.ready       = r_ready;
   assign bus.mem_ce      = (r_state == S_RUN) && !r_isRef;
   assign bus.mem_refresh = (r_state == S_RUN) &&  r_isRef;
   assign bus.mem_we      = r_we;
   assign bus.mem_addr    = r_addr;
   assign bus.mem_din     = r_din;
   assign bus.mem_bs      = r_bs;
   assign bus.a_ack       = (r_state == S_GAP) && !r_isRef && !r_portB;
   assign bus.b_ack       = (r_state == S_GAP) && !r_isRef &&  r_portB;
   assign bus.a_dout      = r_aDout;
   assign bus.b_dout      = r_bDout;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: init burst counting, a vector table of client accesses,
// hand-written contention/refresh/reset sequences and a randomized run against a cycle model.
module tb_sdram_arbiter;

   localparam int CYCLE_LEN        = 8;
   localparam int REFRESH_INTERVAL = 999;
   localparam int INIT_CYCLES      = 1610;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   testsRun = 0;
   int   testsFailed = 0;

   sdram_arbiter_if bus ();

   sdram_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit portB, input bit we, input logic [23:0] addr,
                                input logic [15:0] din, input logic [1:0] bs);
      if (portB) begin
         bus.b_we = we; bus.b_addr = addr; bus.b_din = din; bus.b_bs = bs; bus.b_req = 1'b1;
      end else begin
         bus.a_we = we; bus.a_addr = addr; bus.a_din = din; bus.a_bs = bs; bus.a_req = 1'b1;
      end
   endtask

   task automatic waitSignal(input int which, input int limit, input string name, output int when);
      when = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if ((which == 0 && bus.mem_ce) || (which == 1 && bus.mem_refresh) ||
             (which == 2 && bus.a_ack)  || (which == 3 && bus.b_ack)) begin
            when = cyc;
            break;
         end
      end
      if (when < 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s: no event within %0d cycles, expected one", name, limit);
      end
   endtask

   // Controller read data: returned only on the 8th clock of mem_ce, its complement otherwise.
   bit          useOverride = 1'b0;
   logic [15:0] rdOverride = '0;
   int          ceRun = 0;

   function automatic logic [15:0] rdValue(input logic [23:0] addr);
      return useOverride ? rdOverride : (addr[15:0] ^ {addr[23:16], 8'h5A});
   endfunction

   always @(negedge clk) begin
      if (bus.mem_ce) begin
         bus.mem_dout = (ceRun == CYCLE_LEN - 1) ? rdValue(bus.mem_addr) : ~rdValue(bus.mem_addr);
         ceRun++;
      end else begin
         ceRun = 0;
         bus.mem_dout = 16'h0000;
      end
   end

   // Reference model: one transaction in flight; a grant in cycle n owns cycles n+1..n+9,
   // refresh becomes pending every REFRESH_INTERVAL cycles counted from the first ready cycle.
   typedef struct {
      bit          valid;
      bit          isRef;
      bit          portB;
      bit          we;
      logic [23:0] addr;
      logic [15:0] din;
      logic [1:0]  bs;
      int          s;
   } txn_t;

   txn_t        cur;
   bit          modelOn = 1'b0;
   int          readyCyc = 0;
   int          freeAt = 0;
   int          lastRefGrant = -10;
   bit          pending = 1'b0;
   int          modelN;
   logic [15:0] expADout = '0;
   logic [15:0] expBDout = '0;

   always @(posedge clk) begin
      if (modelOn && cyc >= readyCyc) begin
         modelN = cyc;
         if (lastRefGrant == modelN - 1) pending = 1'b0;
         if (modelN > readyCyc && ((modelN - readyCyc) % REFRESH_INTERVAL) == 0) pending = 1'b1;
         if (modelN >= freeAt && (pending || bus.a_req || bus.b_req)) begin
            cur.valid = 1'b1;
            cur.s     = modelN + 1;
            freeAt    = modelN + CYCLE_LEN + 2;
            if (pending) begin
               cur.isRef    = 1'b1;
               lastRefGrant = modelN;
            end else if (bus.a_req) begin
               cur.isRef = 1'b0; cur.portB = 1'b0; cur.we = bus.a_we;
               cur.addr = bus.a_addr; cur.din = bus.a_din; cur.bs = bus.a_bs;
            end else begin
               cur.isRef = 1'b0; cur.portB = 1'b1; cur.we = bus.b_we;
               cur.addr = bus.b_addr; cur.din = bus.b_din; cur.bs = bus.b_bs;
            end
         end
      end
   end

   int chkM;
   bit chkActive;
   bit chkAck;

   always @(negedge clk) begin
      if (modelOn && cyc >= readyCyc) begin
         chkM      = cyc;
         chkActive = cur.valid && chkM >= cur.s && chkM < cur.s + CYCLE_LEN;
         chkAck    = cur.valid && !cur.isRef && chkM == cur.s + CYCLE_LEN;
         if (chkAck && !cur.we) begin
            if (cur.portB) expBDout = rdValue(cur.addr);
            else           expADout = rdValue(cur.addr);
         end
         checkOutput("model ce/ref/ackA/ackB", {bus.mem_ce, bus.mem_refresh, bus.a_ack, bus.b_ack},
                     {chkActive && !cur.isRef, chkActive && cur.isRef,
                      chkAck && !cur.portB, chkAck && cur.portB});
         checkOutput("model a_dout", bus.a_dout, expADout);
         checkOutput("model b_dout", bus.b_dout, expBDout);
         checkOutput("model ready", bus.ready, 1'b1);
         if (chkActive && !cur.isRef)
            checkOutput("model mem fields", {bus.mem_we, bus.mem_addr, bus.mem_din, bus.mem_bs},
                        {cur.we, cur.addr, cur.din, cur.bs});
         if (chkActive && cur.isRef)
            checkOutput("model refresh mem_we", bus.mem_we, 1'b0);
      end
   end

   task automatic runInit(output bit ok);
      int pulses = 0, bad = 0, ceSeen = 0, ackSeen = 0, runLen = 0, gapLen = 0;
      bit prevRef = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (bus.ready) begin
            ok = 1'b1;
            bus.a_req = 1'b0;
            bus.b_req = 1'b0;
            break;
         end
         if (bus.mem_ce) ceSeen++;
         if (bus.a_ack || bus.b_ack) ackSeen++;
         if (bus.mem_refresh) begin
            if (!prevRef && pulses > 0 && gapLen != 1) bad++;
            runLen++;
            gapLen = 0;
         end else begin
            if (prevRef) begin
               pulses++;
               if (runLen != CYCLE_LEN) bad++;
               runLen = 0;
            end
            gapLen++;
         end
         prevRef = bus.mem_refresh;
      end
      checkOutput("init ready reached", ok, 1'b1);
      checkOutput("init refresh pulses", pulses, INIT_CYCLES);
      checkOutput("init bad pulse/gap lengths", bad, 0);
      checkOutput("init mem_ce cycles", ceSeen, 0);
      checkOutput("init ack cycles", ackSeen, 0);
      checkOutput("init final gap length", gapLen, 1);
      checkOutput("init refresh low at ready", bus.mem_refresh, 1'b0);
   endtask

   typedef struct {
      bit          portB;
      bit          we;
      logic [23:0] addr;
      logic [15:0] din;
      logic [1:0]  bs;
      logic [15:0] memRd;
      logic [15:0] expADout;
      logic [15:0] expBDout;
   } vec_t;

   initial begin
      vec_t vecs [6];
      bit   ok;
      int   g, c0, c1, ca, cb, rr, rr2;

      vecs[0] = '{1'b0, 1'b1, 24'h012345, 16'hBEEF, 2'b01, 16'h0000, 16'h0000, 16'h0000};
      vecs[1] = '{1'b0, 1'b0, 24'h000100, 16'h1111, 2'b11, 16'hCAFE, 16'hCAFE, 16'h0000};
      vecs[2] = '{1'b1, 1'b0, 24'h00ABCD, 16'h2222, 2'b11, 16'h1357, 16'hCAFE, 16'h1357};
      vecs[3] = '{1'b1, 1'b1, 24'hFFFFFF, 16'h0000, 2'b11, 16'h0000, 16'hCAFE, 16'h1357};
      vecs[4] = '{1'b0, 1'b0, 24'h800000, 16'h3333, 2'b10, 16'hFFFF, 16'hFFFF, 16'h1357};
      vecs[5] = '{1'b1, 1'b0, 24'h123456, 16'h4444, 2'b01, 16'h0F0F, 16'hFFFF, 16'h0F0F};

      bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_din = '0; bus.a_bs = '0;
      bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_din = '0; bus.b_bs = '0;
      bus.mem_dout = '0;

      repeat (3) @(negedge clk);
      checkOutput("reset strobes/ready", {bus.ready, bus.mem_ce, bus.mem_refresh, bus.a_ack, bus.b_ack, bus.mem_we}, 6'b0);
      checkOutput("reset mem_addr", bus.mem_addr, 24'h0);
      checkOutput("reset mem_din/bs", {bus.mem_din, bus.mem_bs}, 18'h0);
      checkOutput("reset douts", {bus.a_dout, bus.b_dout}, 32'h0);

      // Requests held through init must be ignored.
      bus.a_req = 1'b1;
      bus.b_req = 1'b1;
      reset = 1'b0;
      runInit(ok);

      if (ok) begin
         readyCyc = cyc;
         freeAt   = cyc;
         cur.valid = 1'b0;
         modelOn  = 1'b1;

         foreach (vecs[k]) begin
            @(negedge clk);
            useOverride = 1'b1;
            rdOverride  = vecs[k].memRd;
            applyStimulus(vecs[k].portB, vecs[k].we, vecs[k].addr, vecs[k].din, vecs[k].bs);
            g = cyc;
            waitSignal(0, 20, "vec mem_ce", c0);
            checkOutput($sformatf("vec%0d ce start", k), c0 - g, 1);
            checkOutput($sformatf("vec%0d mem fields", k), {bus.mem_we, bus.mem_addr, bus.mem_din, bus.mem_bs},
                        {vecs[k].we, vecs[k].addr, vecs[k].din, vecs[k].bs});
            waitSignal(vecs[k].portB ? 3 : 2, 20, "vec ack", ca);
            checkOutput($sformatf("vec%0d latency", k), ca - g, 9);
            checkOutput($sformatf("vec%0d a_dout", k), bus.a_dout, vecs[k].expADout);
            checkOutput($sformatf("vec%0d b_dout", k), bus.b_dout, vecs[k].expBDout);
            bus.a_req = 1'b0;
            bus.b_req = 1'b0;
            repeat (2) @(negedge clk);
         end

         // Contention: both ports request together, A first, B in the IDLE after A's ack.
         @(negedge clk);
         applyStimulus(1'b0, 1'b1, 24'h0A0A0A, 16'h1111, 2'b11);
         applyStimulus(1'b1, 1'b1, 24'h0B0B0B, 16'h2222, 2'b11);
         g = cyc;
         waitSignal(0, 20, "contention first ce", c0);
         checkOutput("contention first ce start", c0 - g, 1);
         checkOutput("contention first addr", bus.mem_addr, 24'h0A0A0A);
         waitSignal(2, 20, "contention a_ack", ca);
         checkOutput("contention a latency", ca - g, 9);
         bus.a_req = 1'b0;
         waitSignal(0, 20, "contention second ce", c1);
         checkOutput("contention b grant after a_ack", c1 - ca, 2);
         checkOutput("contention second addr", bus.mem_addr, 24'h0B0B0B);
         waitSignal(3, 20, "contention b_ack", cb);
         checkOutput("contention b ack timing", cb - c1, 8);
         bus.b_req = 1'b0;

         // Refresh pending and a_req in the same IDLE cycle.
         useOverride = 1'b0;
         while (cyc < readyCyc + REFRESH_INTERVAL) @(negedge clk);
         applyStimulus(1'b0, 1'b0, 24'h00F00D, 16'h0000, 2'b11);
         waitSignal(1, 20, "prio refresh", rr);
         checkOutput("prio refresh start", rr - (readyCyc + REFRESH_INTERVAL), 1);
         checkOutput("prio no ce during refresh", bus.mem_ce, 1'b0);
         waitSignal(0, 30, "prio a ce", c0);
         checkOutput("prio a after refresh", c0 - rr, 10);
         waitSignal(2, 20, "prio a_ack", ca);
         checkOutput("prio a_dout", bus.a_dout, 16'hF057);
         bus.a_req = 1'b0;
         waitSignal(1, 1100, "refresh period", rr2);
         checkOutput("refresh period", rr2 - rr, REFRESH_INTERVAL);

         for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.a_req && bus.a_ack) bus.a_req = 1'b0;
            else if (!bus.a_req && $urandom_range(0, 3) == 0)
               applyStimulus(1'b0, 1'($urandom), 24'($urandom), 16'($urandom), 2'($urandom));
            if (bus.b_req && bus.b_ack) bus.b_req = 1'b0;
            else if (!bus.b_req && $urandom_range(0, 3) == 0)
               applyStimulus(1'b1, 1'($urandom), 24'($urandom), 16'($urandom), 2'($urandom));
         end
         bus.a_req = 1'b0;
         bus.b_req = 1'b0;
         repeat (12) @(negedge clk);

         // Asynchronous reset while the access sits at counter 3.
         applyStimulus(1'b0, 1'b1, 24'h0C0C0C, 16'h5555, 2'b11);
         waitSignal(0, 30, "mid-run ce", c0);
         repeat (3) @(negedge clk);
         checkOutput("mid-run ce before reset", bus.mem_ce, 1'b1);
         modelOn = 1'b0;
         #1;
         reset = 1'b1;
         bus.b_req = 1'b1;
         #1;
         checkOutput("mid-run reset strobes", {bus.mem_ce, bus.mem_refresh, bus.a_ack, bus.b_ack, bus.ready}, 5'b0);
         checkOutput("mid-run reset mem_addr", bus.mem_addr, 24'h0);
         @(negedge clk);
         reset = 1'b0;
         runInit(ok);
         repeat (4) @(negedge clk);
         checkOutput("post reinit idle", {bus.mem_ce, bus.a_ack, bus.b_ack, bus.ready}, 4'b0001);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #3000000;
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
